// File: rtl/phase_readout.sv
// ---------------------------------------------------------------------------
// phase_readout
//
// Reads out the solution of the Ising core. The N free-running oscillator
// outputs of core_matrix are synchronised into the clk domain. After a start
// request the block waits SETTLE_CYCLES for the network to settle. It then
// spends SAMPLE_CYCLES taking a majority vote of whether each spin agrees
// with spin 0. Finally it publishes the anti-phase bitmap as the solution
// vector.
//
// Ports
//   clk       in   system clock, rising edge
//   rstn      in   synchronous active-low reset
//   start     in   readout request, honoured only while idle
//   osc_in    in   [N-1:0] oscillator outputs, asynchronous to clk
//   busy      out  high while a readout is in progress
//   valid     out  solution/no_osc hold a completed result
//   solution  out  [N-1:0] bit i set when spin i is anti-phase to spin 0
//   no_osc    out  spin 0 showed fewer than MIN_EDGES rising edges
// ---------------------------------------------------------------------------
module phase_readout #(
   parameter int N             = 5,
   parameter int SETTLE_CYCLES = 1024,
   parameter int SAMPLE_CYCLES = 256,
   parameter int MIN_EDGES     = 2
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         start,
   input  logic [N-1:0] osc_in,
   output logic         busy,
   output logic         valid,
   output logic [N-1:0] solution,
   output logic         no_osc
);

   localparam int PHASE_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
   localparam int PW        = $clog2(PHASE_MAX + 1);
   localparam int AW        = $clog2(SAMPLE_CYCLES + 1);
   localparam int AW1       = AW + 1;
   localparam int EW        = (MIN_EDGES < 1) ? 1 : $clog2(MIN_EDGES + 1);

   localparam logic [PW-1:0] SETTLE_LAST = PW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [PW-1:0] SAMPLE_LAST = PW'(SAMPLE_CYCLES - 1);
   localparam logic [AW:0]   SAMPLE_LIM  = AW1'(SAMPLE_CYCLES);
   localparam logic [EW-1:0] EDGE_SAT    = EW'(MIN_EDGES);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   state_t        state_reg;
   logic [N-1:0]  meta_reg;
   logic [N-1:0]  sync_reg;
   logic          sync0_d_reg;
   logic [PW-1:0] phase_cnt_reg;
   logic [EW-1:0] edge_cnt_reg;
   logic          busy_reg;
   logic          valid_reg;
   logic [N-1:0]  solution_reg;
   logic          no_osc_reg;

   logic [N-1:0]  anti_phase;
   logic          accept;
   logic          sampling;
   logic          rise0;

   assign accept   = (state_reg == IDLE) && start;
   assign sampling = (state_reg == SAMPLE);
   assign rise0    = sync_reg[0] && !sync0_d_reg;

   // Two-flop synchroniser per spin. A third copy of spin 0 is kept for
   // rising-edge detection.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         meta_reg    <= '0;
         sync_reg    <= '0;
         sync0_d_reg <= 1'b0;
      end else begin
         meta_reg    <= osc_in;
         sync_reg    <= meta_reg;
         sync0_d_reg <= sync_reg[0];
      end
   end

   // Spin 0 is the phase reference, so it is never anti-phase to itself.
   assign anti_phase[0] = 1'b0;

   // One agreement counter per non-reference spin. A spin is anti-phase when
   // it agreed with spin 0 on strictly fewer than half of the samples. An
   // exact tie reports in-phase.
   genvar gi;
   generate
      for (gi = 1; gi < N; gi++) begin : g_spin
         logic [AW-1:0] agree_reg;

         always_ff @(posedge clk) begin
            if (!rstn) begin
               agree_reg <= '0;
            end else if (accept) begin
               agree_reg <= '0;
            end else if (sampling && (sync_reg[gi] == sync_reg[0])) begin
               agree_reg <= agree_reg + 1'b1;
            end
         end

         assign anti_phase[gi] = ({agree_reg, 1'b0} < SAMPLE_LIM);
      end
   endgenerate

   // Control FSM. All outputs are registered here.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg     <= IDLE;
         phase_cnt_reg <= '0;
         edge_cnt_reg  <= '0;
         busy_reg      <= 1'b0;
         valid_reg     <= 1'b0;
         solution_reg  <= '0;
         no_osc_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  valid_reg     <= 1'b0;
                  no_osc_reg    <= 1'b0;
                  busy_reg      <= 1'b1;
                  edge_cnt_reg  <= '0;
                  phase_cnt_reg <= '0;
                  state_reg     <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
               end
            end
            SETTLE: begin
               if (phase_cnt_reg == SETTLE_LAST) begin
                  phase_cnt_reg <= '0;
                  state_reg     <= SAMPLE;
               end else begin
                  phase_cnt_reg <= phase_cnt_reg + 1'b1;
               end
            end
            SAMPLE: begin
               // The count saturates, so a fast oscillator cannot wrap it
               // back below the threshold.
               if (rise0 && (edge_cnt_reg != EDGE_SAT)) begin
                  edge_cnt_reg <= edge_cnt_reg + 1'b1;
               end
               if (phase_cnt_reg == SAMPLE_LAST) begin
                  phase_cnt_reg <= '0;
                  state_reg     <= DONE;
               end else begin
                  phase_cnt_reg <= phase_cnt_reg + 1'b1;
               end
            end
            DONE: begin
               solution_reg <= anti_phase;
               no_osc_reg   <= (edge_cnt_reg < EDGE_SAT);
               valid_reg    <= 1'b1;
               busy_reg     <= 1'b0;
               state_reg    <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_reg;
   assign valid    = valid_reg;
   assign solution = solution_reg;
   assign no_osc   = no_osc_reg;

endmodule

// File: tb/tb_phase_readout.sv
// ---------------------------------------------------------------------------
// tb_phase_readout
//
// Directed bench for phase_readout with N=5, SETTLE_CYCLES=4 and
// SAMPLE_CYCLES=64. Each start pushes the expected result and its due cycle
// into a scoreboard queue. A monitor pops an entry on every rising edge of
// valid and compares the result against it.
// ---------------------------------------------------------------------------
module tb_phase_readout;

   localparam int N  = 5;
   localparam int S  = 4;
   localparam int M  = 64;
   localparam int ME = 2;

   logic         clk  = 1'b0;
   logic         rstn = 1'b0;
   logic         start = 1'b0;
   logic [N-1:0] osc_in = '0;
   logic         busy;
   logic         valid;
   logic [N-1:0] solution;
   logic         no_osc;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;
   int tick  = 0;

   // Per-spin waveform kind: 0 = W, 1 = ~W, 2 = W lagging by 4 cycles,
   // 3 = held 0, 4 = held 1. W is a square wave with a period of 16 cycles.
   int kind [N] = '{0, 0, 0, 0, 0};

   typedef struct {
      int           due;
      logic [N-1:0] sol;
      logic         nosc;
   } exp_t;

   exp_t sb_q[$];

   phase_readout #(
      .N(N), .SETTLE_CYCLES(S), .SAMPLE_CYCLES(M), .MIN_EDGES(ME)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .osc_in(osc_in),
      .busy(busy), .valid(valid), .solution(solution), .no_osc(no_osc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic wave_bit(input int k, input int t);
      case (k)
         0:       return ((t % 16) < 8);
         1:       return !((t % 16) < 8);
         2:       return (((t + 12) % 16) < 8);
         3:       return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_kinds(input int k0, input int k1, input int k2, input int k3, input int k4);
      kind[0] = k0; kind[1] = k1; kind[2] = k2; kind[3] = k3; kind[4] = k4;
   endtask

   // Oscillator driver: the inputs change on the falling edge, away from the
   // DUT's sampling edge.
   initial begin
      forever begin
         @(negedge clk);
         tick++;
         for (int i = 0; i < N; i++) osc_in[i] = wave_bit(kind[i], tick);
      end
   end

   // Monitor: compares each newly presented result with the oldest expectation.
   initial begin
      logic v_prev;
      exp_t e;
      v_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (valid && !v_prev) begin
            if (sb_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_valid: got valid=1 at cycle %0d, required no pending readout", cyc);
            end else begin
               e = sb_q.pop_front();
               chk("result_time", cyc, e.due);
               chk("solution", 32'(solution), 32'(e.sol));
               chk("no_osc", 32'(no_osc), 32'(e.nosc));
               $display("readout cycle=%0d solution=%b no_osc=%b (expected %b/%b at %0d)",
                        cyc, solution, no_osc, e.sol, e.nosc, e.due);
            end
         end
         v_prev = valid;
      end
   end

   // Pulse start for one cycle and push the expected result. Returns the
   // acceptance edge index t. The caller is left at the negedge following t.
   task automatic do_start(input logic [N-1:0] sol, input logic nosc, output int t);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      t     = cyc + 1;
      e.due  = t + S + M + 1;
      e.sol  = sol;
      e.nosc = nosc;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("valid_cleared_on_start", 32'(valid), 32'd0);
   endtask

   task automatic wait_result();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL result_timeout: got no valid within 500 cycles, required a result");
         sb_q.delete();
      end
   endtask

   task automatic check_hold(input logic [N-1:0] sol);
      repeat (5) @(negedge clk);
      chk("valid_hold", 32'(valid), 32'd1);
      chk("solution_hold", 32'(solution), 32'(sol));
   endtask

   initial begin
      int t;

      // Reset with activity on every input.
      rstn  = 1'b0;
      start = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_valid", 32'(valid), 32'd0);
         chk("rst_no_osc", 32'(no_osc), 32'd0);
         chk("rst_solution", 32'(solution), 32'd0);
      end
      rstn  = 1'b1;
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_valid", 32'(valid), 32'd0);

      // All spins in phase.
      set_kinds(0, 0, 0, 0, 0);
      do_start(5'b00000, 1'b0, t);
      wait_result();
      check_hold(5'b00000);

      // Max-cut pattern: A,D on W; B,C,E on ~W.
      set_kinds(0, 1, 1, 0, 1);
      do_start(5'b10110, 1'b0, t);
      wait_result();
      check_hold(5'b10110);

      // Quadrature spin 1 (exact tie -> 0), anti-phase spin 2.
      set_kinds(0, 2, 1, 0, 0);
      do_start(5'b00100, 1'b0, t);
      wait_result();
      check_hold(5'b00100);

      // Dead reference: spin 0 held low. Spin 1 and spin 2 tie, spin 3 held
      // high never agrees, spin 4 held low always agrees. A second start
      // issued while busy must not disturb the result or its timing.
      set_kinds(3, 0, 1, 4, 3);
      do_start(5'b01000, 1'b1, t);
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_ignores_start", 32'(busy), 32'd1);
      wait_result();
      check_hold(5'b01000);

      // Reset 30 cycles into SAMPLE, then a fresh full readout.
      set_kinds(0, 1, 1, 0, 1);
      do_start(5'b10110, 1'b0, t);
      while (cyc < t + S + 30) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      sb_q.delete();
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_valid", 32'(valid), 32'd0);
      repeat (80) @(negedge clk);
      chk("midrst_no_partial", 32'(valid), 32'd0);
      do_start(5'b10110, 1'b0, t);
      wait_result();
      check_hold(5'b10110);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
